// File: rtl/pipeline_control.sv
// Hazard and pipeline-control unit for the 5-stage core.
// Drives stall, bubble and flush enables plus perf counters.
module pipeline_control #(
  parameter int REG_AW = 5,
  parameter int LAT_W  = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              branch_taken,
  input  logic              mc_start,
  input  logic [LAT_W-1:0]  mc_cycles,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_write,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              mc_busy,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
);

  typedef enum logic {
    RUN,
    MC_BUSY
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [LAT_W-1:0]   cnt;
  logic [LAT_W-1:0]   cnt_n;
  logic [CNT_W-1:0]   stall_q;
  logic [CNT_W-1:0]   flush_q;
  logic               load_use;
  logic               mc_go;
  logic               rs1_hit;
  logic               rs2_hit;

  // x0 is hardwired, so a load to it never creates a hazard
  assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_mem_read && (ex_rd != '0)
                    && (rs1_hit || rs2_hit);
  assign mc_go    = mc_start && (mc_cycles >= LAT_W'(2));

  // Next-state and control enables; reset forces the idle values
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (mc_go) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
            if (mc_cycles > LAT_W'(2)) begin
              state_n = MC_BUSY;
              cnt_n   = mc_cycles - LAT_W'(2);
            end
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        MC_BUSY: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_flush = 1'b1;
          cnt_n        = cnt - LAT_W'(1);
          if (cnt == LAT_W'(1)) begin
            state_n = RUN;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  // State register and saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      cnt     <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (!pc_write && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (if_id_flush && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign mc_busy      = !rst && (state == MC_BUSY);
  assign stall_cycles = rst ? '0 : stall_q;
  assign flush_events = rst ? '0 : flush_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench for pipeline_control.
// Directed steps then random traffic against a cycle model.
module tb_pipeline_control;

  localparam int REG_AW = 5;
  localparam int LAT_W  = 4;
  localparam int CNT_W  = 3;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rd;
  logic              branch_taken;
  logic              mc_start;
  logic [LAT_W-1:0]  mc_cycles;
  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_write;
  logic              id_ex_flush;
  logic              ex_mem_flush;
  logic              mc_busy;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_events;

  int checks = 0;
  int errors = 0;

  // model state: stall cycles still owed, and counters
  int m_left = 0;
  int m_sc   = 0;
  int m_fe   = 0;

  pipeline_control #(
    .REG_AW(REG_AW),
    .LAT_W (LAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .branch_taken(branch_taken),
    .mc_start    (mc_start),
    .mc_cycles   (mc_cycles),
    .pc_write    (pc_write),
    .if_id_write (if_id_write),
    .if_id_flush (if_id_flush),
    .id_ex_write (id_ex_write),
    .id_ex_flush (id_ex_flush),
    .ex_mem_flush(ex_mem_flush),
    .mc_busy     (mc_busy),
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst          = 1'b0;
    id_rs1       = '0;
    id_rs2       = '0;
    id_uses_rs1  = 1'b0;
    id_uses_rs2  = 1'b0;
    ex_mem_read  = 1'b0;
    ex_rd        = '0;
    branch_taken = 1'b0;
    mc_start     = 1'b0;
    mc_cycles    = '0;
  endtask

  task automatic load_use_in(input int r);
    ex_mem_read = 1'b1;
    ex_rd       = REG_AW'(r);
    id_rs1      = REG_AW'(r);
    id_uses_rs1 = 1'b1;
  endtask

  // Predict one cycle from the rules, check mid-cycle, advance
  task automatic do_cycle();
    logic e_pw, e_ifw, e_idw, e_iff, e_idf, e_exf, e_busy;
    logic lu;
    int nl, nsc, nfe, n;
    e_pw  = 1'b1; e_ifw = 1'b1; e_idw = 1'b1;
    e_iff = 1'b0; e_idf = 1'b0; e_exf = 1'b0;
    e_busy = !rst && (m_left > 0);
    nl = m_left; nsc = m_sc; nfe = m_fe;
    n  = int'(mc_cycles);
    lu = ex_mem_read && (ex_rd != 0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) ||
          (id_uses_rs2 && id_rs2 == ex_rd));
    if (rst) begin
      nl = 0; nsc = 0; nfe = 0;
    end else if (m_left > 0) begin
      e_pw = 0; e_ifw = 0; e_idw = 0; e_exf = 1;
      nl = m_left - 1;
    end else if (branch_taken) begin
      e_iff = 1; e_idf = 1;
    end else if (mc_start && n >= 2) begin
      e_pw = 0; e_ifw = 0; e_idw = 0; e_exf = 1;
      nl = n - 2;
    end else if (lu) begin
      e_pw = 0; e_ifw = 0; e_idf = 1;
    end
    if (!rst && !e_pw && nsc < CMAX) nsc++;
    if (!rst && e_iff && nfe < CMAX) nfe++;
    #4;
    chk("pc_write", pc_write, e_pw);
    chk("if_id_write", if_id_write, e_ifw);
    chk("id_ex_write", id_ex_write, e_idw);
    chk("if_id_flush", if_id_flush, e_iff);
    chk("id_ex_flush", id_ex_flush, e_idf);
    chk("ex_mem_flush", ex_mem_flush, e_exf);
    chk("mc_busy", mc_busy, e_busy);
    chk("stall_cycles", stall_cycles, rst ? 0 : m_sc);
    chk("flush_events", flush_events, rst ? 0 : m_fe);
    @(posedge clk);
    #1;
    m_left = nl; m_sc = nsc; m_fe = nfe;
  endtask

  task automatic reset_dut();
    idle();
    rst = 1'b1;
    do_cycle();
    // inputs must not leak through while in reset
    load_use_in(3);
    branch_taken = 1'b1;
    do_cycle();
    idle();
  endtask

  initial begin
    int busy_seen;
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    reset_dut();
    do_cycle();

    // load-use on rs1, then the same with ex_rd = x0
    load_use_in(5);
    do_cycle();
    idle();
    do_cycle();
    chk("lu_stall_count", stall_cycles, 1);
    load_use_in(0);
    do_cycle();
    idle();
    ex_mem_read = 1'b1; ex_rd = 9;
    id_rs2 = 9; id_uses_rs2 = 1'b1;
    do_cycle();
    idle();
    do_cycle();

    // branch wins over load-use
    load_use_in(7);
    branch_taken = 1'b1;
    do_cycle();
    idle();
    do_cycle();

    // latency 4: three stall cycles
    reset_dut();
    busy_seen = 0;
    mc_start = 1'b1; mc_cycles = 4;
    do_cycle();
    idle();
    for (int i = 0; i < 4; i++) begin
      if (mc_busy) busy_seen++;
      do_cycle();
    end
    chk("n4_busy_cycles", busy_seen, 2);
    chk("n4_stall_count", stall_cycles, 3);

    // latency 2 and 1
    mc_start = 1'b1; mc_cycles = 2;
    do_cycle();
    idle();
    do_cycle();
    mc_start = 1'b1; mc_cycles = 1;
    do_cycle();
    mc_cycles = 0;
    do_cycle();
    idle();
    do_cycle();

    // reset in the third stall of a latency-8 op
    mc_start = 1'b1; mc_cycles = 8;
    do_cycle();
    idle();
    do_cycle();
    rst = 1'b1;
    do_cycle();
    idle();
    do_cycle();
    chk("rst_mid_busy", mc_busy, 0);
    do_cycle();

    // hold load-use for 10 cycles: counter sticks at max
    load_use_in(12);
    for (int i = 0; i < 10; i++) do_cycle();
    idle();
    do_cycle();
    chk("sat_stall", stall_cycles, CMAX);

    // longest latency op
    reset_dut();
    mc_start = 1'b1; mc_cycles = 15;
    do_cycle();
    idle();
    for (int i = 0; i < 16; i++) do_cycle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 39) == 0);
      id_rs1       = REG_AW'($urandom_range(0, 3));
      id_rs2       = REG_AW'($urandom_range(0, 3));
      id_uses_rs1  = 1'($urandom);
      id_uses_rs2  = 1'($urandom);
      ex_mem_read  = 1'($urandom);
      ex_rd        = REG_AW'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 5) == 0);
      mc_start     = ($urandom_range(0, 7) == 0);
      mc_cycles    = LAT_W'($urandom);
      do_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
